// File: rtl/time_digit_writer.sv
// rtl/time_digit_writer.sv - nibble-at-a-time HH:MM BCD editor with blink and commit strobe
module time_digit_writer #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic        next,
    input  logic        inc,
    input  logic        dec,
    input  logic [15:0] load_val,
    output logic [15:0] work_val,
    output logic [1:0]  cursor,
    output logic        editing,
    output logic        blink,
    output logic        commit_valid,
    output logic [15:0] commit_val
);

    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {IDLE, EDIT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [15:0]     work_q, work_d;
    logic [1:0]      cursor_q, cursor_d;
    logic            blink_q, blink_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     cval_q, cval_d;
    logic [3:0]      digit, lim, nd;

    // Minutes nibbles are cleared individually; any out-of-range hours value clears both hour nibbles.
    function automatic logic [15:0] sanitise(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        if (v[3:0] > 4'd9) r[3:0] = 4'd0;
        if (v[7:4] > 4'd5) r[7:4] = 4'd0;
        if (v[15:12] > 4'd2 || v[11:8] > 4'd9 || (v[15:12] == 4'd2 && v[11:8] > 4'd3))
            r[15:8] = 8'h00;
        return r;
    endfunction

    // State register for the FSM, working value, cursor, blink phase and committed value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= 16'h0000;
            cursor_q <= 2'd0;
            blink_q  <= 1'b1;
            cnt_q    <= '0;
            cval_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            cursor_q <= cursor_d;
            blink_q  <= blink_d;
            cnt_q    <= cnt_d;
            cval_q   <= cval_d;
        end
    end

    // Next-state logic: one action per cycle in EDIT, priority cancel > next > inc/dec.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        cursor_d = cursor_q;
        blink_d  = blink_q;
        cnt_d    = cnt_q;
        cval_d   = cval_q;
        digit    = 4'd0;
        lim      = 4'd9;
        nd       = 4'd0;

        case (cursor_q)
            2'd0:    begin digit = work_q[3:0];   lim = 4'd9; end
            2'd1:    begin digit = work_q[7:4];   lim = 4'd5; end
            2'd2:    begin digit = work_q[11:8];  lim = (work_q[15:12] == 4'd2) ? 4'd3 : 4'd9; end
            default: begin digit = work_q[15:12]; lim = 4'd2; end
        endcase

        if (inc)
            nd = (digit >= lim) ? 4'd0 : digit + 4'd1;
        else
            nd = (digit == 4'd0 || digit > lim) ? lim : digit - 4'd1;

        case (state_q)
            IDLE: begin
                blink_d = 1'b1;
                cnt_d   = '0;
                if (start) begin
                    state_d  = EDIT;
                    work_d   = sanitise(load_val);
                    cursor_d = 2'd3;
                end
            end
            EDIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    blink_d = ~blink_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (cancel) begin
                    state_d = IDLE;
                    blink_d = 1'b1;
                    cnt_d   = '0;
                end else if (next) begin
                    blink_d = 1'b1;
                    cnt_d   = '0;
                    if (cursor_q == 2'd0) begin
                        state_d = COMMIT;
                        cval_d  = work_q;
                    end else begin
                        cursor_d = cursor_q - 2'd1;
                    end
                end else if (inc ^ dec) begin
                    case (cursor_q)
                        2'd0:    work_d[3:0]   = nd;
                        2'd1:    work_d[7:4]   = nd;
                        2'd2:    work_d[11:8]  = nd;
                        default: work_d[15:12] = nd;
                    endcase
                    // Moving hours tens to 2 must pull hours ones into 0..3.
                    if (work_d[15:12] == 4'd2 && work_d[11:8] > 4'd3)
                        work_d[11:8] = 4'd3;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                blink_d = 1'b1;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign work_val     = work_q;
    assign cursor       = cursor_q;
    assign editing      = (state_q == EDIT);
    assign blink        = blink_q;
    assign commit_valid = (state_q == COMMIT);
    assign commit_val   = cval_q;

endmodule

// File: tb/tb_time_digit_writer.sv
// tb/tb_time_digit_writer.sv - table-driven scoreboard bench for time_digit_writer
module tb_time_digit_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0, cancel = 1'b0, next = 1'b0, inc = 1'b0, dec = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic [15:0] work_val, commit_val;
    logic [1:0]  cursor;
    logic        editing, blink, commit_valid;

    int tests = 0;
    int fails = 0;
    int ncommit = 0;

    localparam logic [4:0] NO = 5'b00000, S = 5'b10000, C = 5'b01000, N = 5'b00100, I = 5'b00010, D = 5'b00001;

    typedef struct {
        logic [4:0]  act;
        logic [15:0] ld;
        logic [15:0] w;
        logic [1:0]  cur;
        logic        ed;
        logic        cv;
        logic [15:0] cval;
        logic        bc;
        logic        bl;
    } vec_t;

    vec_t tbl[$];
    vec_t sbq[$];
    int   vidx = 0;

    time_digit_writer #(.BLINK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .cancel(cancel), .next(next),
        .inc(inc), .dec(dec), .load_val(load_val), .work_val(work_val),
        .cursor(cursor), .editing(editing), .blink(blink),
        .commit_valid(commit_valid), .commit_val(commit_val)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [4:0] a, input logic [15:0] ld, input logic [15:0] w,
                                input logic [1:0] cur, input logic ed, input logic cv,
                                input logic [15:0] cval, input logic bc, input logic bl);
        vec_t v;
        v.act = a; v.ld = ld; v.w = w; v.cur = cur; v.ed = ed; v.cv = cv;
        v.cval = cval; v.bc = bc; v.bl = bl;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        {start, cancel, next, inc, dec} = v.act;
        load_val = v.ld;
        sbq.push_back(v);
    endtask

    task automatic quiet();
        @(negedge clk);
        {start, cancel, next, inc, dec} = NO;
    endtask

    // Scoreboard: compare the oldest pending expectation shortly after each rising edge.
    always @(posedge clk) begin
        vec_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("work_val", vidx, work_val, e.w);
            check("cursor", vidx, {14'd0, cursor}, {14'd0, e.cur});
            check("editing", vidx, {15'd0, editing}, {15'd0, e.ed});
            check("commit_valid", vidx, {15'd0, commit_valid}, {15'd0, e.cv});
            check("commit_val", vidx, commit_val, e.cval);
            if (e.bc) check("blink", vidx, {15'd0, blink}, {15'd0, e.bl});
            vidx++;
        end
    end

    always @(negedge clk) if (commit_valid) ncommit++;

    initial begin
        // plain sequences: 0730 straight through, 2359 edits, 1945 coupling, 9999 sanitise, 0850 wraps
        tbl.push_back(mk(S,     16'h0730, 16'h0730, 2'd3, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0730, 2'd2, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0730, 2'd1, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0730, 2'd0, 1, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0730, 2'd0, 0, 1, 16'h0730, 0, 0));
        tbl.push_back(mk(NO,    16'h0000, 16'h0730, 2'd0, 0, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(S,     16'h2359, 16'h2359, 2'd3, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h2359, 2'd2, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h2359, 2'd1, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(D,     16'h0000, 16'h2349, 2'd1, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h2359, 2'd1, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h2309, 2'd1, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h2309, 2'd0, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h2300, 2'd0, 1, 0, 16'h0730, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h2300, 2'd0, 0, 1, 16'h2300, 0, 0));
        tbl.push_back(mk(NO,    16'h0000, 16'h2300, 2'd0, 0, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(S,     16'h1945, 16'h1945, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h2345, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h0345, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(D,     16'h0000, 16'h2345, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h2345, 2'd2, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h2045, 2'd2, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(D,     16'h0000, 16'h2345, 2'd2, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(C,     16'h0000, 16'h2345, 2'd2, 0, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h2345, 2'd2, 0, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(S,     16'h9999, 16'h0009, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(I | D, 16'h0000, 16'h0009, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N | I, 16'h0000, 16'h0009, 2'd2, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(C | N, 16'h0000, 16'h0009, 2'd2, 0, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0009, 2'd2, 0, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(S,     16'h0800, 16'h0800, 2'd3, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0800, 2'd2, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0800, 2'd1, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(D,     16'h0000, 16'h0850, 2'd1, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0850, 2'd0, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(D,     16'h0000, 16'h0859, 2'd0, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(I,     16'h0000, 16'h0850, 2'd0, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(S,     16'h1111, 16'h0850, 2'd0, 1, 0, 16'h2300, 0, 0));
        tbl.push_back(mk(N,     16'h0000, 16'h0850, 2'd0, 0, 1, 16'h0850, 0, 0));
        tbl.push_back(mk(NO,    16'h0000, 16'h0850, 2'd0, 0, 0, 16'h0850, 0, 0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst work_val", -1, work_val, 16'h0000);
        check("rst cursor", -1, {14'd0, cursor}, 16'h0000);
        check("rst editing", -1, {15'd0, editing}, 16'h0000);
        check("rst blink", -1, {15'd0, blink}, 16'h0001);
        check("rst commit_valid", -1, {15'd0, commit_valid}, 16'h0000);
        check("rst commit_val", -1, commit_val, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);

        // blink phase with BLINK_DIV=4, restart on next, cancel keeps commit_val
        apply(mk(S,  16'h0000, 16'h0000, 2'd3, 1, 0, 16'h0850, 1, 1));
        for (int k = 0; k < 3; k++) apply(mk(NO, 16'h0000, 16'h0000, 2'd3, 1, 0, 16'h0850, 1, 1));
        for (int k = 0; k < 2; k++) apply(mk(NO, 16'h0000, 16'h0000, 2'd3, 1, 0, 16'h0850, 1, 0));
        apply(mk(N,  16'h0000, 16'h0000, 2'd2, 1, 0, 16'h0850, 1, 1));
        for (int k = 0; k < 3; k++) apply(mk(NO, 16'h0000, 16'h0000, 2'd2, 1, 0, 16'h0850, 1, 1));
        apply(mk(NO, 16'h0000, 16'h0000, 2'd2, 1, 0, 16'h0850, 1, 0));
        apply(mk(C,  16'h0000, 16'h0000, 2'd2, 0, 0, 16'h0850, 1, 1));
        apply(mk(NO, 16'h0000, 16'h0000, 2'd2, 0, 0, 16'h0850, 1, 1));

        // asynchronous reset between edges while editing
        apply(mk(S,  16'h1234, 16'h1234, 2'd3, 1, 0, 16'h0850, 0, 0));
        apply(mk(I,  16'h0000, 16'h2234, 2'd3, 1, 0, 16'h0850, 0, 0));
        @(posedge clk);
        #3;
        {start, cancel, next, inc, dec} = NO;
        reset = 1'b1;
        #1;
        check("async work_val", -2, work_val, 16'h0000);
        check("async cursor", -2, {14'd0, cursor}, 16'h0000);
        check("async editing", -2, {15'd0, editing}, 16'h0000);
        check("async blink", -2, {15'd0, blink}, 16'h0001);
        check("async commit_valid", -2, {15'd0, commit_valid}, 16'h0000);
        check("async commit_val", -2, commit_val, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        apply(mk(S,  16'h0730, 16'h0730, 2'd3, 1, 0, 16'h0000, 1, 1));
        apply(mk(N,  16'h0000, 16'h0730, 2'd2, 1, 0, 16'h0000, 0, 0));
        apply(mk(N,  16'h0000, 16'h0730, 2'd1, 1, 0, 16'h0000, 0, 0));
        apply(mk(N,  16'h0000, 16'h0730, 2'd0, 1, 0, 16'h0000, 0, 0));
        apply(mk(N,  16'h0000, 16'h0730, 2'd0, 0, 1, 16'h0730, 0, 0));
        apply(mk(NO, 16'h0000, 16'h0730, 2'd0, 0, 0, 16'h0730, 1, 1));
        quiet();

        for (int k = 0; k < 20 && sbq.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard drained", -3, 16'(sbq.size()), 16'h0000);
        check("commit strobe count", -3, 16'(ncommit), 16'd4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
